// File: rtl/cpu_bus_sched.sv
// Z80 clock-enable sequencer and CPU/video RAM port arbiter.
// Video gets the RAM in CPU idle windows, or by force after a bounded wait.
module cpu_bus_sched #(
    parameter int DIV     = 8,
    parameter int VID_LEN = 2,
    parameter int MAXWAIT = 12
) (
    input  logic clock,
    input  logic reset,
    output logic cep,
    output logic cen,
    input  logic mreq,
    input  logic rfsh,
    input  logic wr,
    input  logic vreq,
    output logic vack,
    output logic ram_sel,
    output logic ram_we,
    output logic stall
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_CPU = 2'd0,
        S_VID = 2'd1,
        S_REC = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] ph;
    logic [7:0]    vw;
    logic [3:0]    vc;
    logic          cpu_busy;
    logic          grant;

    assign cpu_busy = ~mreq & rfsh;
    assign grant    = (state == S_CPU) & vreq
                    & (~cpu_busy | (vw == 8'(MAXWAIT)));

    // Enables are gated by reset so they drop asynchronously with it.
    assign cep = reset & ~stall & (ph == PW'(0));
    assign cen = reset & ~stall & (ph == PW'(DIV / 2));

    assign ram_we = ~wr & ~mreq & rfsh & ~ram_sel & ~stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_CPU;
            ph      <= '0;
            vw      <= '0;
            vc      <= '0;
            vack    <= 1'b0;
            ram_sel <= 1'b0;
            stall   <= 1'b0;
        end else begin
            if (!stall) begin
                if (ph == PW'(DIV - 1))
                    ph <= '0;
                else
                    ph <= ph + PW'(1);
            end
            vack <= 1'b0;
            unique case (state)
                S_CPU: begin
                    if (grant) begin
                        state   <= S_VID;
                        ram_sel <= 1'b1;
                        stall   <= 1'b1;
                        vw      <= '0;
                        vc      <= 4'(VID_LEN - 1);
                        vack    <= (VID_LEN == 1);
                    end else if (vreq) begin
                        vw <= vw + 8'd1;
                    end else begin
                        vw <= '0;
                    end
                end
                S_VID: begin
                    if (vc == 4'd0) begin
                        state   <= S_REC;
                        ram_sel <= 1'b0;
                    end else begin
                        vc   <= vc - 4'd1;
                        vack <= (vc == 4'd1);
                    end
                end
                S_REC: begin
                    // One idle clock lets synchronous RAM data settle for the CPU.
                    state <= S_CPU;
                    stall <= 1'b0;
                end
                default: begin
                    state   <= S_CPU;
                    ram_sel <= 1'b0;
                    stall   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_sched.sv
// Directed bench for cpu_bus_sched with DIV=8, VID_LEN=2, MAXWAIT=12.
module tb_cpu_bus_sched;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic cep, cen, vack, ram_sel, ram_we, stall;
    logic mreq = 1'b1;
    logic rfsh = 1'b1;
    logic wr   = 1'b1;
    logic vreq = 1'b0;

    int checks   = 0;
    int failures = 0;
    int eph;

    cpu_bus_sched #(.DIV(8), .VID_LEN(2), .MAXWAIT(12)) dut (
        .clock  (clock),
        .reset  (reset),
        .cep    (cep),
        .cen    (cen),
        .mreq   (mreq),
        .rfsh   (rfsh),
        .wr     (wr),
        .vreq   (vreq),
        .vack   (vack),
        .ram_sel(ram_sel),
        .ram_we (ram_we),
        .stall  (stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_cep", cep, 1'b0);
        chk("rst_cen", cen, 1'b0);
        chk("rst_vack", vack, 1'b0);
        chk("rst_sel", ram_sel, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_stall", stall, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("first_cep", cep, 1'b1);
        chk("first_cen", cen, 1'b0);

        // Free run: cep at ph 0, cen at ph 4
        eph = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            eph = (eph + 1) % 8;
            chk("fr_cep", cep, eph == 0);
            chk("fr_cen", cen, eph == 4);
            chk("fr_stall", stall, 1'b0);
        end

        // Idle grant, vreq rising with ph==0
        vreq = 1'b1;
        #0;
        chk("id_cep_same", cep, 1'b1);
        chk("id_sel_n", ram_sel, 1'b0);
        tick();
        chk("id_sel_n1", ram_sel, 1'b1);
        chk("id_stall_n1", stall, 1'b1);
        chk("id_cep_n1", cep, 1'b0);
        chk("id_vack_n1", vack, 1'b0);
        tick();
        chk("id_sel_n2", ram_sel, 1'b1);
        chk("id_vack_n2", vack, 1'b1);
        vreq = 1'b0;
        tick();
        chk("id_sel_n3", ram_sel, 1'b0);
        chk("id_stall_n3", stall, 1'b1);
        chk("id_vack_n3", vack, 1'b0);
        chk("id_cep_n3", cep, 1'b0);
        tick();
        chk("id_stall_n4", stall, 1'b0);
        chk("id_cep_n4", cep, 1'b0);
        tick();
        tick();
        tick();
        chk("id_cen_resume", cen, 1'b1);

        // Forced grant during a CPU write cycle, ph=4
        mreq = 1'b0;
        rfsh = 1'b1;
        wr   = 1'b0;
        vreq = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            #0;
            chk("fw_sel_wait", ram_sel, 1'b0);
            chk("fw_we_wait", ram_we, 1'b1);
            if (k == 12)
                chk("fw_cep_k12", cep, 1'b1);
            tick();
        end
        chk("fw_sel_grant", ram_sel, 1'b1);
        chk("fw_stall_grant", stall, 1'b1);
        chk("fw_we_vid", ram_we, 1'b0);
        tick();
        chk("fw_vack", vack, 1'b1);
        chk("fw_we_vid2", ram_we, 1'b0);
        vreq = 1'b0;
        tick();
        chk("fw_rec_sel", ram_sel, 1'b0);
        chk("fw_rec_stall", stall, 1'b1);
        chk("fw_we_rec", ram_we, 1'b0);
        tick();
        chk("fw_stall_off", stall, 1'b0);
        chk("fw_we_back", ram_we, 1'b1);
        chk("fw_cep_frozen", cep, 1'b0);
        tick();
        tick();
        tick();
        chk("fw_cen_resume", cen, 1'b1);

        // Refresh cycle: immediate grant, no write enable
        rfsh = 1'b0;
        vreq = 1'b1;
        #0;
        chk("rf_we_n", ram_we, 1'b0);
        chk("rf_cen_n", cen, 1'b1);
        tick();
        chk("rf_sel_n1", ram_sel, 1'b1);
        chk("rf_we_n1", ram_we, 1'b0);
        chk("rf_cen_n1", cen, 1'b0);
        tick();
        chk("rf_vack_n2", vack, 1'b1);
        vreq = 1'b0;
        tick();
        chk("rf_stall_n3", stall, 1'b1);
        chk("rf_we_n3", ram_we, 1'b0);
        tick();
        chk("rf_stall_n4", stall, 1'b0);
        chk("rf_we_n4", ram_we, 1'b0);

        // Back-to-back requests, ph=5
        mreq = 1'b1;
        rfsh = 1'b1;
        wr   = 1'b1;
        vreq = 1'b1;
        tick();
        chk("bb_sel_q1", ram_sel, 1'b1);
        tick();
        chk("bb_vack_q2", vack, 1'b1);
        tick();
        chk("bb_sel_q3", ram_sel, 1'b0);
        chk("bb_stall_q3", stall, 1'b1);
        tick();
        chk("bb_sel_gap", ram_sel, 1'b0);
        chk("bb_stall_gap", stall, 1'b0);
        chk("bb_vack_gap", vack, 1'b0);
        chk("bb_cep_gap", cep, 1'b0);
        tick();
        chk("bb_sel_q5", ram_sel, 1'b1);
        chk("bb_stall_q5", stall, 1'b1);
        tick();
        chk("bb_vack_q6", vack, 1'b1);
        vreq = 1'b0;
        tick();
        chk("bb_rec_q7", stall, 1'b1);
        tick();
        chk("bb_stall_q8", stall, 1'b0);
        chk("bb_cep_q8", cep, 1'b0);
        tick();
        chk("bb_cep_q9", cep, 1'b1);

        // Reset asserted mid-VID
        vreq = 1'b1;
        tick();
        chk("rv_sel_vid", ram_sel, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("rv_sel", ram_sel, 1'b0);
        chk("rv_stall", stall, 1'b0);
        chk("rv_cep", cep, 1'b0);
        chk("rv_cen", cen, 1'b0);
        chk("rv_vack", vack, 1'b0);
        vreq = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rv_first_cep", cep, 1'b1);
        chk("rv_stall_rel", stall, 1'b0);
        tick();
        chk("rv_cep_next", cep, 1'b0);
        chk("rv_no_vack", vack, 1'b0);
        chk("rv_sel_next", ram_sel, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
